hes_cipher_framer: RTL and testbench

Downstream stage of the AES stream cipher: it consumes the cipher's per-byte output (`output_valid`, `output_byte`, `counter_block`) and buffers it in an internal FIFO. It re-emits the data as framed packets on a ready/valid byte stream for the host link. Every frame is SOF marker, starting counter, payload, length and XOR checksum. The cipher has no backpressure, so the framer must absorb every valid byte and flag overflow.

---
 rtl/hes_cipher_framer.sv | 150 +++++++++++++++
 tb/tb_hes_cipher_framer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hes_cipher_framer.sv
// Framer for the AES stream cipher output: buffers cipher bytes and emits SOF/CTR/payload/LEN/CHK frames.
// Latency: a byte written at the end of cycle 0 appears as SOF in cycle 2, CTR in cycle 3 and payload in cycle 4.
// Backpressure: out_ready stalls the output stream only; the input never stalls, so bytes arriving at a full FIFO are dropped and overflow is set.
module hes_cipher_framer #(
  parameter int          DEPTH    = 16,
  parameter int          MAX_LEN  = 16,
  parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_byte,
  input  logic [7:0]                 in_ctr,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
  output logic                       out_sof,
  output logic                       out_eof,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SOF  = 3'd1,
    S_CTR  = 3'd2,
    S_PAY  = 3'd3,
    S_LEN  = 3'd4,
    S_CHK  = 3'd5
  } state_t;

  state_t        state, state_nxt;
  logic [16:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [16:0]   head;
  logic          empty, full, fire, pop, push, last_tag;
  logic [7:0]    in_cnt, chk, len;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign fifo_level = wr_ptr - rd_ptr;

  assign fire     = out_valid && out_ready;
  assign pop      = (state == S_PAY) && fire;
  // A pop in the same cycle frees a slot, so a write at full is still accepted.
  assign push     = in_valid && (!full || pop);
  assign last_tag = in_last || (in_cnt == 8'(MAX_LEN - 1));

  // FIFO storage: entry is {last, ctr, byte}; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {last_tag, in_ctr, in_byte};
  end

  // FIFO pointers, input frame counter and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // The counter advances even for dropped bytes so MAX_LEN splitting keeps tracking the cipher stream.
      if (in_valid) in_cnt <= last_tag ? 8'd0 : in_cnt + 8'd1;
      if (in_valid && full && !pop) overflow <= 1'b1;
    end
  end

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: every transition except IDLE->SOF waits for a handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!empty) state_nxt = S_SOF;
      S_SOF:   if (fire) state_nxt = S_CTR;
      S_CTR:   if (fire) state_nxt = S_PAY;
      S_PAY:   if (fire && head[16]) state_nxt = S_LEN;
      S_LEN:   if (fire) state_nxt = S_CHK;
      S_CHK:   if (fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from registered state and FIFO head; only PAY can drop valid (FIFO starved).
  always_comb begin
    out_valid = 1'b0;
    out_data  = 8'd0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    case (state)
      S_SOF: begin
        out_valid = 1'b1;
        out_data  = SOF_BYTE;
        out_sof   = 1'b1;
      end
      S_CTR: begin
        out_valid = 1'b1;
        out_data  = head[15:8];
      end
      S_PAY: begin
        out_valid = !empty;
        out_data  = head[7:0];
      end
      S_LEN: begin
        out_valid = 1'b1;
        out_data  = len;
      end
      S_CHK: begin
        out_valid = 1'b1;
        out_data  = chk;
        out_eof   = 1'b1;
      end
      default: ;
    endcase
  end

  // Running checksum and payload length, seeded by the counter beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk <= 8'd0;
      len <= 8'd0;
    end else if (fire) begin
      case (state)
        S_CTR: begin
          chk <= head[15:8];
          len <= 8'd0;
        end
        S_PAY: begin
          chk <= chk ^ head[7:0];
          len <= len + 8'd1;
        end
        S_LEN:   chk <= chk ^ len;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hes_cipher_framer.sv
module tb_hes_cipher_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_last;
  logic [7:0] in_byte, in_ctr;
  logic       out_valid, out_ready, out_sof, out_eof, overflow;
  logic [7:0] out_data;
  logic [2:0] fifo_level;

  int n_checks = 0;
  int n_pass   = 0;

  // Expected beats: {sof, eof, data}
  logic [9:0] sb[$];

  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  logic [9:0] exp_b;

  logic [7:0] bp_b [3] = '{8'h81, 8'h82, 8'h83};
  logic [7:0] bp_c [3] = '{8'h50, 8'h51, 8'h52};

  hes_cipher_framer #(.DEPTH(4), .MAX_LEN(4), .SOF_BYTE(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ctr     (in_ctr),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eof    (out_eof),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic sof, input logic eof);
    sb.push_back({sof, eof, d});
  endtask

  task automatic send(input logic [7:0] b, input logic [7:0] c, input logic l);
    in_valid = 1'b1;
    in_byte  = b;
    in_ctr   = c;
    in_last  = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(posedge clk);
      i++;
    end
    check({name, "_drained"}, sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks hold-while-stalled.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_beat: got %0h expected none", out_data);
        end else begin
          exp_b = sb.pop_front();
          check("beat", {out_sof, out_eof, out_data}, exp_b);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_byte = 8'd0; in_ctr = 8'd0; in_last = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sof", out_sof, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single frame: chk = 05^11^22^33^03 = 06
    exp_beat(8'hA5, 1, 0); exp_beat(8'h05, 0, 0); exp_beat(8'h11, 0, 0);
    exp_beat(8'h22, 0, 0); exp_beat(8'h33, 0, 0); exp_beat(8'h03, 0, 0); exp_beat(8'h06, 0, 1);
    send(8'h11, 8'h05, 0); send(8'h22, 8'h06, 0); send(8'h33, 8'h07, 1);
    wait_drain("single");

    // MAX_LEN=4 split: chk1 = 10^01^02^03^04^04 = 10, chk2 = 14^05^06^02 = 15
    exp_beat(8'hA5, 1, 0); exp_beat(8'h10, 0, 0); exp_beat(8'h01, 0, 0); exp_beat(8'h02, 0, 0);
    exp_beat(8'h03, 0, 0); exp_beat(8'h04, 0, 0); exp_beat(8'h04, 0, 0); exp_beat(8'h10, 0, 1);
    exp_beat(8'hA5, 1, 0); exp_beat(8'h14, 0, 0); exp_beat(8'h05, 0, 0); exp_beat(8'h06, 0, 0);
    exp_beat(8'h02, 0, 0); exp_beat(8'h15, 0, 1);
    for (int i = 0; i < 6; i++) send(8'(i + 1), 8'(8'h10 + i), i == 5);
    wait_drain("split");
    check("split_overflow", overflow, 0);

    // Backpressure with out_ready 1-0-1-0: chk = 50^81^82^83^03 = D3
    exp_beat(8'hA5, 1, 0); exp_beat(8'h50, 0, 0); exp_beat(8'h81, 0, 0); exp_beat(8'h82, 0, 0);
    exp_beat(8'h83, 0, 0); exp_beat(8'h03, 0, 0); exp_beat(8'hD3, 0, 1);
    for (int i = 0; i < 20; i++) begin
      out_ready = (i % 2 == 0);
      if (i < 3) begin
        in_valid = 1'b1; in_byte = bp_b[i]; in_ctr = bp_c[i]; in_last = (i == 2);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_drain("backpressure");

    // Starvation mid-frame: chk = 20^41^42^02 = 21
    exp_beat(8'hA5, 1, 0); exp_beat(8'h20, 0, 0); exp_beat(8'h41, 0, 0);
    exp_beat(8'h42, 0, 0); exp_beat(8'h02, 0, 0); exp_beat(8'h21, 0, 1);
    send(8'h41, 8'h20, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("starve_gap_valid", out_valid, 0);
    @(posedge clk); #1;
    send(8'h42, 8'h21, 1);
    wait_drain("starve");

    // Overflow: 61..64 stored (64 tagged last by MAX_LEN), 65/66 dropped; chk = 30^61^62^63^64^04 = 30
    out_ready = 1'b0;
    exp_beat(8'hA5, 1, 0); exp_beat(8'h30, 0, 0); exp_beat(8'h61, 0, 0); exp_beat(8'h62, 0, 0);
    exp_beat(8'h63, 0, 0); exp_beat(8'h64, 0, 0); exp_beat(8'h04, 0, 0); exp_beat(8'h30, 0, 1);
    for (int i = 0; i < 6; i++) send(8'(8'h61 + i), 8'(8'h30 + i), i == 5);
    repeat (3) @(posedge clk); #1;
    check("ovf_level", fifo_level, 4);
    check("ovf_flag", overflow, 1);
    out_ready = 1'b1;
    wait_drain("overflow");
    check("ovf_sticky", overflow, 1);

    // Reset during PAY beat, then a fresh frame: chk = 09^AB^01 = A3
    exp_beat(8'hA5, 1, 0); exp_beat(8'h40, 0, 0);
    send(8'h71, 8'h40, 0);
    repeat (3) @(posedge clk); #1;
    check("pay_valid_before_rst", out_valid, 1);
    check("pay_data_before_rst", out_data, 8'h71);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sof", out_sof, 0);
    check("midrst_out_eof", out_eof, 0);
    check("midrst_fifo_level", fifo_level, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_beats_seen", sb.size(), 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_beat(8'hA5, 1, 0); exp_beat(8'h09, 0, 0); exp_beat(8'hAB, 0, 0);
    exp_beat(8'h01, 0, 0); exp_beat(8'hA3, 0, 1);
    send(8'hAB, 8'h09, 1);
    wait_drain("after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
